// File: rtl/regfile_ras_multiport_if.sv
// Decode/execute-facing bundle for the register file and return-address stack.
// Port-style names are kept so signals trace directly to the block's pin list.
interface regfile_ras_multiport_if #(
    parameter int XLEN       = 32,
    parameter int REG_BITS   = 5,
    parameter int READ_PORTS = 2
);
    logic                         write_i;
    logic [REG_BITS-1:0]          rd_addr_i;
    logic [XLEN-1:0]              data_i;
    logic [READ_PORTS*REG_BITS-1:0] rs_addr_i;
    logic [READ_PORTS*XLEN-1:0]   rs_data_o;
    logic [XLEN-1:0]              pc_i;
    logic                         push_ras_i;
    logic                         pop_ras_i;
    logic [XLEN-1:0]              ras_o;
    logic                         ras_valid_o;
    logic                         overflow_o;
    logic                         underflow_o;

    modport master (
        output write_i, rd_addr_i, data_i, rs_addr_i, pc_i, push_ras_i, pop_ras_i,
        input  rs_data_o, ras_o, ras_valid_o, overflow_o, underflow_o
    );

    modport slave (
        input  write_i, rd_addr_i, data_i, rs_addr_i, pc_i, push_ras_i, pop_ras_i,
        output rs_data_o, ras_o, ras_valid_o, overflow_o, underflow_o
    );
endinterface

// File: rtl/regfile_ras_multiport.sv
// Integer register file (N read ports, 1 write port, optional write bypass)
// with a circular return-address stack and sticky overflow/underflow flags.
module regfile_ras_multiport #(
    parameter int XLEN       = 32,
    parameter int REG_BITS   = 5,
    parameter int READ_PORTS = 2,
    parameter int RAS_BITS   = 4,
    parameter bit BYPASS     = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    regfile_ras_multiport_if.slave bus
);
    localparam int NREG      = 1 << REG_BITS;
    localparam int RAS_DEPTH = 1 << RAS_BITS;
    localparam logic [RAS_BITS:0] RAS_FULL = {1'b1, {RAS_BITS{1'b0}}};

    logic [XLEN-1:0]            regs_q [NREG];
    logic [NREG-1:0]            valid_q, valid_d;
    logic [READ_PORTS*XLEN-1:0] rs_data_q, rs_data_d;

    logic [XLEN-1:0]     ras_q [RAS_DEPTH];
    logic [RAS_BITS-1:0] tp_q, tp_d;
    logic [RAS_BITS:0]   cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic                ras_we;
    logic [RAS_BITS-1:0] ras_waddr;
    logic [XLEN-1:0]     ret_addr;
    logic                wr_en;
    logic                ras_empty;

    assign wr_en     = bus.write_i && (bus.rd_addr_i != '0);
    assign ret_addr  = bus.pc_i + XLEN'(4);
    assign ras_empty = (cnt_q == '0);

    always_comb begin
        valid_d = valid_q;
        if (wr_en) begin
            valid_d[bus.rd_addr_i] = 1'b1;
        end
    end

    // Invalid registers read as zero, which also keeps x0 at zero forever.
    always_comb begin
        rs_data_d = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            if (BYPASS && wr_en && (bus.rs_addr_i[p*REG_BITS +: REG_BITS] == bus.rd_addr_i)) begin
                rs_data_d[p*XLEN +: XLEN] = bus.data_i;
            end else if (valid_q[bus.rs_addr_i[p*REG_BITS +: REG_BITS]]) begin
                rs_data_d[p*XLEN +: XLEN] = regs_q[bus.rs_addr_i[p*REG_BITS +: REG_BITS]];
            end
        end
    end

    always_comb begin
        tp_d      = tp_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        ras_we    = 1'b0;
        ras_waddr = tp_q + RAS_BITS'(1);
        if (bus.push_ras_i && bus.pop_ras_i && !ras_empty) begin
            // Tail call: replace the current return target in place.
            ras_we    = 1'b1;
            ras_waddr = tp_q;
        end else if (bus.push_ras_i) begin
            ras_we = 1'b1;
            tp_d   = tp_q + RAS_BITS'(1);
            if (cnt_q == RAS_FULL) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + (RAS_BITS+1)'(1);
            end
        end else if (bus.pop_ras_i) begin
            if (ras_empty) begin
                unf_d = 1'b1;
            end else begin
                tp_d  = tp_q - RAS_BITS'(1);
                cnt_d = cnt_q - (RAS_BITS+1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q   <= '0;
            rs_data_q <= '0;
            tp_q      <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            rs_data_q <= rs_data_d;
            tp_q      <= tp_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_en) begin
            regs_q[bus.rd_addr_i] <= bus.data_i;
        end
        if (!rst_i && ras_we) begin
            ras_q[ras_waddr] <= ret_addr;
        end
    end

    assign bus.rs_data_o   = rs_data_q;
    assign bus.ras_o       = ras_empty ? '0 : ras_q[tp_q];
    assign bus.ras_valid_o = !ras_empty;
    assign bus.overflow_o  = ovf_q;
    assign bus.underflow_o = unf_q;
endmodule

// File: tb/tb_regfile_ras_multiport.sv
// Bench for regfile_ras_multiport: a bypassing and a non-bypassing instance
// share stimulus; register reads go through an expectation queue.
module tb_regfile_ras_multiport;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_ras_multiport_if #(.XLEN(32), .REG_BITS(5), .READ_PORTS(2)) ifa ();
    regfile_ras_multiport_if #(.XLEN(32), .REG_BITS(5), .READ_PORTS(2)) ifb ();

    regfile_ras_multiport #(.XLEN(32), .REG_BITS(5), .READ_PORTS(2), .RAS_BITS(4), .BYPASS(1'b1))
        dut_byp (.clk_i(clk), .rst_i(rst), .bus(ifa));
    regfile_ras_multiport #(.XLEN(32), .REG_BITS(5), .READ_PORTS(2), .RAS_BITS(4), .BYPASS(1'b0))
        dut_nobyp (.clk_i(clk), .rst_i(rst), .bus(ifb));

    assign ifb.write_i    = ifa.write_i;
    assign ifb.rd_addr_i  = ifa.rd_addr_i;
    assign ifb.data_i     = ifa.data_i;
    assign ifb.rs_addr_i  = ifa.rs_addr_i;
    assign ifb.pc_i       = ifa.pc_i;
    assign ifb.push_ras_i = ifa.push_ras_i;
    assign ifb.pop_ras_i  = ifa.pop_ras_i;

    typedef struct {
        string       name;
        bit          wr;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] exp0;
        logic [31:0] exp1;
        logic [31:0] expnb0;
    } vec_t;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } sb_t;

    vec_t vecs [9];
    sb_t  sbq [$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic idle_inputs();
        ifa.write_i    = 1'b0;
        ifa.rd_addr_i  = '0;
        ifa.data_i     = '0;
        ifa.rs_addr_i  = '0;
        ifa.pc_i       = '0;
        ifa.push_ras_i = 1'b0;
        ifa.pop_ras_i  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic drain_sb();
        logic [31:0] act;
        while (sbq.size() != 0) begin
            sb_t e;
            e = sbq.pop_front();
            case (e.sel)
                0:       act = ifa.rs_data_o[31:0];
                1:       act = ifa.rs_data_o[63:32];
                default: act = ifb.rs_data_o[31:0];
            endcase
            chk(e.name, act, e.exp);
        end
    endtask

    task automatic ras_op(input bit push, input bit pop, input logic [31:0] pc);
        ifa.push_ras_i = push;
        ifa.pop_ras_i  = pop;
        ifa.pc_i       = pc;
        tick();
        ifa.push_ras_i = 1'b0;
        ifa.pop_ras_i  = 1'b0;
    endtask

    task automatic chk_ras(input string name, input logic [31:0] top, input bit vld,
                           input bit ovf, input bit unf);
        chk({name, "_top"}, ifa.ras_o, top);
        chk({name, "_vld"}, {31'b0, ifa.ras_valid_o}, {31'b0, vld});
        chk({name, "_ovf"}, {31'b0, ifa.overflow_o}, {31'b0, ovf});
        chk({name, "_unf"}, {31'b0, ifa.underflow_o}, {31'b0, unf});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            name        wr  rd  wdata         ra0 ra1 exp0          exp1          expnb0
        vecs[0] = '{"wr_x5",     1, 5, 32'hDEADBEEF, 1,  2,  32'h0,        32'h0,        32'h0};
        vecs[1] = '{"rd_x5",     0, 0, 32'h0,        5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2] = '{"wr_x0",     1, 0, 32'h00001234, 0,  5,  32'h0,        32'hDEADBEEF, 32'h0};
        vecs[3] = '{"rd_x0",     0, 0, 32'h0,        0,  0,  32'h0,        32'h0,        32'h0};
        vecs[4] = '{"byp_x7",    1, 7, 32'hA5A5A5A5, 7,  3,  32'hA5A5A5A5, 32'h0,        32'h0};
        vecs[5] = '{"rd_x7",     0, 0, 32'h0,        7,  5,  32'hA5A5A5A5, 32'hDEADBEEF, 32'hA5A5A5A5};
        vecs[6] = '{"byp_x5",    1, 5, 32'h12345678, 5,  7,  32'h12345678, 32'hA5A5A5A5, 32'hDEADBEEF};
        vecs[7] = '{"byp_x31",   1, 31, 32'hFFFFFFFF, 31, 5, 32'hFFFFFFFF, 32'h12345678, 32'h0};
        vecs[8] = '{"rd_x31",    0, 0, 32'h0,        31, 31, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};

        idle_inputs();
        do_reset();
        chk("rst_rs_a", ifa.rs_data_o[31:0], 32'h0);
        chk("rst_rs_b", ifb.rs_data_o[63:32], 32'h0);
        chk_ras("rst", 32'h0, 1'b0, 1'b0, 1'b0);

        for (int r = 0; r < 32; r++) begin
            ifa.rs_addr_i = {r[4:0], r[4:0]};
            sbq.push_back('{$sformatf("init_x%0d_p0", r), 0, 32'h0});
            sbq.push_back('{$sformatf("init_x%0d_p1", r), 1, 32'h0});
            tick();
            drain_sb();
        end

        for (int i = 0; i < 9; i++) begin
            ifa.write_i   = vecs[i].wr;
            ifa.rd_addr_i = vecs[i].rd;
            ifa.data_i    = vecs[i].wdata;
            ifa.rs_addr_i = {vecs[i].ra1, vecs[i].ra0};
            sbq.push_back('{{vecs[i].name, "_p0"}, 0, vecs[i].exp0});
            sbq.push_back('{{vecs[i].name, "_p1"}, 1, vecs[i].exp1});
            sbq.push_back('{{vecs[i].name, "_nb0"}, 2, vecs[i].expnb0});
            tick();
            drain_sb();
        end
        idle_inputs();

        ras_op(1, 0, 32'h100);
        chk_ras("push100", 32'h104, 1'b1, 1'b0, 1'b0);
        ras_op(1, 0, 32'h200);
        chk_ras("push200", 32'h204, 1'b1, 1'b0, 1'b0);
        ras_op(0, 1, 32'h0);
        chk_ras("pop1", 32'h104, 1'b1, 1'b0, 1'b0);
        ras_op(0, 1, 32'h0);
        chk_ras("pop2", 32'h0, 1'b0, 1'b0, 1'b0);
        ras_op(0, 1, 32'h0);
        chk_ras("pop3_under", 32'h0, 1'b0, 1'b0, 1'b1);
        tick();
        chk_ras("under_sticky", 32'h0, 1'b0, 1'b0, 1'b1);

        do_reset();
        chk_ras("rst2", 32'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) begin
            ras_op(1, 0, 32'h1000 + 32'(16 * i));
            if (i == 15) chk_ras("push16", 32'h10F4, 1'b1, 1'b0, 1'b0);
        end
        chk_ras("push17_ovf", 32'h1104, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("wrap_top%0d", k), ifa.ras_o, 32'h1000 + 32'(16 * (16 - k)) + 32'h4);
            ras_op(0, 1, 32'h0);
        end
        chk_ras("wrap_empty", 32'h0, 1'b0, 1'b1, 1'b0);
        ras_op(0, 1, 32'h0);
        chk_ras("wrap_under", 32'h0, 1'b0, 1'b1, 1'b1);

        do_reset();
        ras_op(1, 0, 32'h300);
        chk_ras("tc_push", 32'h304, 1'b1, 1'b0, 1'b0);
        ras_op(1, 1, 32'h400);
        chk_ras("tail_call", 32'h404, 1'b1, 1'b0, 1'b0);
        ras_op(0, 1, 32'h0);
        chk_ras("tail_cnt1", 32'h0, 1'b0, 1'b0, 1'b0);
        ras_op(1, 1, 32'h500);
        chk_ras("tail_empty", 32'h504, 1'b1, 1'b0, 1'b0);
        ras_op(1, 0, 32'hFFFFFFFE);
        chk_ras("pc_wrap", 32'h00000002, 1'b1, 1'b0, 1'b0);

        ifa.write_i   = 1'b1;
        ifa.rd_addr_i = 5'd9;
        ifa.data_i    = 32'hCAFEF00D;
        tick();
        ifa.write_i   = 1'b0;
        ifa.rs_addr_i = {5'd9, 5'd9};
        tick();
        chk("pre_rst_rd", ifa.rs_data_o[31:0], 32'hCAFEF00D);
        ifa.write_i    = 1'b1;
        ifa.rd_addr_i  = 5'd9;
        ifa.data_i     = 32'h11111111;
        ifa.push_ras_i = 1'b1;
        ifa.pc_i       = 32'h600;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        ifa.rs_addr_i = {5'd9, 5'd9};
        chk("midrst_rs0", ifa.rs_data_o[31:0], 32'h0);
        chk("midrst_rs1", ifa.rs_data_o[63:32], 32'h0);
        chk_ras("midrst", 32'h0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("post_rst_x9", ifa.rs_data_o[31:0], 32'h0);
        chk("post_rst_x9_nb", ifb.rs_data_o[63:32], 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/regfile_ras_multiport.md
Name: regfile_ras_multiport

Overview:
- Next-generation integer register file with an attached return-address stack (RAS) for the rv32im core.
- Provides a parametrised number of synchronous read ports and one write port, with same-cycle write-to-read bypass.
- Registers clear to zero on reset; x0 reads as zero permanently.
- Circular RAS with defined overflow, underflow and simultaneous push/pop behaviour and sticky status flags; sits between decode (addresses) and execute (operands, return target).

Parameters:
- XLEN, 32, data width of registers and RAS entries.
- REG_BITS, 5, register address width; register count is 2^REG_BITS.
- READ_PORTS, 2, number of independent read ports, range 1..4.
- RAS_BITS, 4, RAS depth is 2^RAS_BITS entries.
- BYPASS, 1, 1 = write data forwarded to same-cycle reads of the same address; 0 = old data returned.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  synchronous active-high reset.
- write_i  in  1  register write enable.
- rd_addr_i  in  REG_BITS  write address.
- data_i  in  XLEN  write data.
- rs_addr_i  in  READ_PORTS*REG_BITS  packed read addresses; port p uses bits [p*REG_BITS +: REG_BITS].
- rs_data_o  out  READ_PORTS*XLEN  packed read data, same packing as rs_addr_i.
- pc_i  in  XLEN  PC of the call instruction.
- push_ras_i  in  1  push pc_i+4.
- pop_ras_i  in  1  pop top entry.
- ras_o  out  XLEN  current top of stack.
- ras_valid_o  out  1  stack non-empty.
- overflow_o  out  1  sticky: a push overwrote the oldest entry.
- underflow_o  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset:
  - Clears the per-register valid vector (2^REG_BITS flops), RAS pointer, RAS count, both sticky flags and all rs_data_o lanes.
  - After reset: rs_data_o = 0, ras_o = 0, ras_valid_o = 0, overflow_o = 0, underflow_o = 0.
  - A register whose valid bit is clear reads 0; the storage array itself is not cleared.
  - Reset dominates all other inputs in the same cycle.
- Write:
  - Occurs when write_i=1 and rd_addr_i!=0: stores data_i and sets that register's valid bit.
  - Writes to x0 are dropped; x0 always reads 0.
- Read:
  - Latency 1 cycle: rs_data_o lane p at cycle k+1 reflects rs_addr_i lane p sampled at cycle k.
  - All ports are independent; any ports may use the same address.
- Bypass:
  - If BYPASS=1, write_i=1, rd_addr_i!=0 and rd_addr_i equals a read address in the same cycle, that lane returns data_i next cycle.
  - If BYPASS=0, that lane returns the pre-write value, or 0 if the register is invalid.
- RAS state:
  - Circular array of 2^RAS_BITS entries, top pointer tp, count cnt (0..2^RAS_BITS).
  - ras_o = entry[tp] when cnt!=0, else 0; driven combinationally from the array and valid in the cycle after the push/pop edge.
- RAS, push only:
  - Writes pc_i+4 (modulo 2^XLEN) to entry[tp+1], then tp++.
  - cnt increments, saturating at 2^RAS_BITS.
  - If cnt was already full, the oldest entry is overwritten and overflow_o is set.
- RAS, pop only:
  - If cnt!=0: tp--, cnt--.
  - If cnt==0: no state change and underflow_o is set.
- RAS, push and pop together (tail call):
  - If cnt!=0: entry[tp] is replaced with pc_i+4; tp and cnt are unchanged.
  - If cnt==0: behaves as push only, and underflow_o is not set.
- Sticky flags: overflow_o and underflow_o clear only on reset.
- Wrap-around: tp arithmetic is modulo 2^RAS_BITS; exactly the most recent 2^RAS_BITS pushes remain retrievable.

Test Plan:
- Reset then read all 32 registers on 2 ports -> every lane reads 0x00000000; ras_valid_o=0, ras_o=0.
- Write x5=0xDEADBEEF, next cycle read x5 on both ports -> both lanes read 0xDEADBEEF one cycle later; write x0=0x1234, read x0 -> 0.
- Same cycle: write x7=0xA5A5A5A5 and read x7 on port 0 -> port 0 reads 0xA5A5A5A5 with BYPASS=1; reads 0 (invalid) with BYPASS=0.
- Push pc_i=0x100, then 0x200, then pop -> ras_o sequence 0x104, 0x204, 0x104; ras_valid_o stays 1; pop again -> ras_valid_o=0, ras_o=0; third pop -> underflow_o=1.
- RAS_BITS=4: push 17 values pc=0x1000+16*i for i=0..16 -> overflow_o=1; 16 pops return 0x1104 down to 0x1014; 17th pop sets underflow_o.
- With cnt=1, top=0x304: push+pop with pc_i=0x400 -> ras_o=0x404, cnt stays 1; assert rst_i mid-sequence -> all flags, outputs and cnt are 0 on the next cycle.
